// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped countdown timer with one-shot and auto-reload modes
module bus_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_next_state;

    logic             r_en;
    logic [1:0]       r_mode;
    logic             r_im;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_count;
    logic             r_irq_flag;

    logic             w_wr_ctrl;
    logic             w_wr_preset;
    logic             w_count_load;
    logic             w_count_dec;
    logic             w_count_clr;
    logic             w_flag_set;
    logic             w_flag_release;
    logic             w_en_clr;
    logic             w_unused_addr;

    assign w_wr_ctrl     = we && (addr[3:2] == 2'd0);
    assign w_wr_preset   = we && (addr[3:2] == 2'd1);
    assign w_unused_addr = &{1'b0, addr[31:4], addr[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = S_CNT;
            end
            S_CNT: begin
                if (!r_en) begin
                    w_next_state = S_IDLE;
                end else if (r_count <= C_ONE) begin
                    w_next_state = S_INT;
                end
            end
            S_INT: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Only mode 1 auto-reloads; modes 0, 2 and 3 are one-shot.
    always_comb begin
        w_count_load   = 1'b0;
        w_count_dec    = 1'b0;
        w_count_clr    = 1'b0;
        w_flag_set     = 1'b0;
        w_flag_release = 1'b0;
        w_en_clr       = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_count_load = 1'b1;
            end
            S_CNT: begin
                if (r_en) begin
                    if (r_count > C_ONE) begin
                        w_count_dec = 1'b1;
                    end else begin
                        w_count_clr = 1'b1;
                        w_flag_set  = 1'b1;
                        w_en_clr    = (r_mode != 2'd1);
                    end
                end
            end
            S_INT: begin
                w_flag_release = (r_mode == 2'd1);
            end
            default: begin
            end
        endcase
    end

    // A bus write always beats the FSM's own update of CTRL and the flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_en       <= 1'b0;
            r_mode     <= 2'd0;
            r_im       <= 1'b0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= wdata[0];
                r_mode <= wdata[2:1];
                r_im   <= wdata[3];
            end else if (w_en_clr) begin
                r_en <= 1'b0;
            end

            if (w_wr_preset) begin
                r_preset <= wdata;
            end

            if (w_count_load) begin
                r_count <= r_preset;
            end else if (w_count_dec) begin
                r_count <= r_count - C_ONE;
            end else if (w_count_clr) begin
                r_count <= '0;
            end

            if (w_wr_ctrl || w_wr_preset) begin
                r_irq_flag <= 1'b0;
            end else if (w_flag_set) begin
                r_irq_flag <= 1'b1;
            end else if (w_flag_release) begin
                r_irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            2'd0:    rdata = {{(WIDTH-4){1'b0}}, r_im, r_mode, r_en};
            2'd1:    rdata = r_preset;
            2'd2:    rdata = r_count;
            default: rdata = '0;
        endcase
    end

    assign irq = r_im & r_irq_flag;

endmodule
